// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes and extends the immediate of a 32-bit instruction to XLEN bits.
// Latency: 1 cycle from accept to out_* when the output stage is empty or draining.
// Backpressure: 2-entry (output + skid) buffer; in_ready is registered (!skid valid), never combinational from out_ready.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_extop,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [31:0]     out_instr,
  output logic            out_err
);

  // One held pipeline entry: extended immediate, the instruction it came from, reserved-format flag.
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [31:0]     instr;
    logic            err;
  } ent_t;

  // Format decode; the leading sign replication absorbs the XLEN difference so no width is ever truncated.
  function automatic logic [XLEN-1:0] ext_imm(input logic [31:0] i, input logic [2:0] op);
    logic [XLEN-1:0] w;
    w = '0;
    case (op)
      3'b000:  w = {{(XLEN-11){i[31]}}, i[30:20]};
      3'b001:  w = {{(XLEN-31){i[31]}}, i[30:12], 12'b0};
      3'b010:  w = {{(XLEN-11){i[31]}}, i[30:25], i[11:7]};
      3'b011:  w = {{(XLEN-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      3'b100:  w = {{(XLEN-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      3'b101:  w = {{(XLEN-5){1'b0}}, i[19:15]};
      3'b110:  w = (XLEN == 64) ? {{(XLEN-6){1'b0}}, i[25:20]} : {{(XLEN-5){1'b0}}, i[24:20]};
      default: w = '0;
    endcase
    return w;
  endfunction

  ent_t out_ent_q, out_ent_d;
  ent_t skid_ent_q, skid_ent_d;
  logic out_vld_q, out_vld_d;
  logic skid_vld_q, skid_vld_d;
  ent_t new_ent;
  logic accept;
  logic fire;

  assign in_ready  = !skid_vld_q;
  assign out_valid = out_vld_q;
  assign out_imm   = out_ent_q.imm;
  assign out_instr = out_ent_q.instr;
  assign out_err   = out_ent_q.err;

  // Next-state of the output/skid pair; flush wins over everything, then drain skid, then direct load, then park in skid.
  always_comb begin
    out_ent_d      = out_ent_q;
    skid_ent_d     = skid_ent_q;
    out_vld_d      = out_vld_q;
    skid_vld_d     = skid_vld_q;
    new_ent.imm    = ext_imm(in_instr, in_extop);
    new_ent.instr  = in_instr;
    new_ent.err    = (in_extop == 3'b111);
    accept         = in_valid && !skid_vld_q;
    fire           = out_vld_q && out_ready;
    if (flush) begin
      out_ent_d  = '0;
      skid_ent_d = '0;
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (fire && skid_vld_q) begin
      out_ent_d = skid_ent_q;
      if (accept) begin
        skid_ent_d = new_ent;
      end else begin
        skid_vld_d = 1'b0;
      end
    end else if ((fire || !out_vld_q) && !skid_vld_q) begin
      if (accept) begin
        out_ent_d = new_ent;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (out_vld_q && !fire && accept) begin
      skid_ent_d = new_ent;
      skid_vld_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ent_q  <= '0;
      skid_ent_q <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      out_ent_q  <= out_ent_d;
      skid_ent_q <= skid_ent_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

endmodule
